// File: rtl/vending_credit_arbiter.sv
// vending_credit_arbiter
// Shares one credit accumulator and one product dispenser between NUM_SLOTS
// coin inlets. Each inlet latches at most one coin. Latched coins are granted
// round-robin, one per cycle, into a common credit count. Once the credit
// covers the price, the block runs a req/ack handshake with the dispenser and
// then reports any change. A cancel request refunds the current credit.

module vending_credit_arbiter #(
    parameter  int NUM_SLOTS   = 2,
    parameter  int PRICE_UNITS = 4,
    localparam int CREDIT_W    = $clog2(PRICE_UNITS + 2)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_SLOTS-1:0] nickel,
    input  logic [NUM_SLOTS-1:0] dime,
    input  logic                 cancel,
    input  logic                 disp_ack,
    output logic                 disp_req,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_units,
    output logic [NUM_SLOTS-1:0] coin_reject,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 busy
);

    // The round-robin pointer needs at least one bit, even with a single inlet.
    localparam int RR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        VEND    = 2'd1,
        CHANGE  = 2'd2
    } state_t;

    state_t               state;
    logic [RR_W-1:0]      rr;

    // Per-inlet coin latch. The value is 1 for a nickel and 2 for a dime.
    logic [NUM_SLOTS-1:0] pend;
    logic [1:0]           val [NUM_SLOTS];

    // Arbitration results for the current cycle.
    logic                 grant_valid;
    logic [RR_W-1:0]      grant_idx;
    logic [RR_W-1:0]      cand;
    logic [CREDIT_W-1:0]  grant_add;
    logic [CREDIT_W-1:0]  credit_after;
    logic [CREDIT_W-1:0]  change_amt;

    // Round-robin pick: the first pending inlet found when scanning from rr+1.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (state == COLLECT && !cancel) begin
            for (int k = 1; k <= NUM_SLOTS; k++) begin
                cand = RR_W'((int'(rr) + k) % NUM_SLOTS);
                if (!grant_valid && pend[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Credit after this cycle's grant, and change owed when a vend completes.
    always_comb begin
        grant_add    = grant_valid ? CREDIT_W'(val[grant_idx]) : '0;
        credit_after = credit + grant_add;
        change_amt   = credit - CREDIT_W'(PRICE_UNITS);
    end

    // Inlet latches: accept a coin into an empty latch, or into a latch being
    // granted on this edge. Otherwise refuse the coin. A nickel and a dime
    // arriving together keep the nickel and refuse the dime.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: only the pend flags are reset. A coin value is never read while its pend flag is clear, so the value storage is left unreset.
            pend        <= '0;
            coin_reject <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (nickel[i] || dime[i]) begin
                    if (pend[i] && !(grant_valid && int'(grant_idx) == i)) begin
                        coin_reject[i] <= 1'b1;
                    end else begin
                        pend[i]        <= 1'b1;
                        val[i]         <= nickel[i] ? 2'd1 : 2'd2;
                        coin_reject[i] <= nickel[i] && dime[i];
                    end
                end else begin
                    coin_reject[i] <= 1'b0;
                    if (grant_valid && int'(grant_idx) == i) begin
                        pend[i] <= 1'b0;
                    end
                end
            end
        end
    end

    // Vend sequencer: COLLECT accumulates credit, VEND runs the dispenser handshake,
    // CHANGE reports a refund or change for exactly one cycle. All outputs are registered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values of the others.
            state        <= COLLECT;
            rr           <= '0;
            credit       <= '0;
            disp_req     <= 1'b0;
            change_valid <= 1'b0;
            change_units <= '0;
            busy         <= 1'b0;
        end else begin
            change_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (cancel) begin
                        // A cancel blocks the grant this cycle. It does nothing when there is no credit.
                        if (credit != '0) begin
                            change_units <= credit;
                            change_valid <= 1'b1;
                            credit       <= '0;
                            busy         <= 1'b1;
                            state        <= CHANGE;
                        end
                    end else begin
                        if (grant_valid) begin
                            rr <= grant_idx;
                        end
                        credit <= credit_after;
                        if (credit_after >= CREDIT_W'(PRICE_UNITS)) begin
                            disp_req <= 1'b1;
                            busy     <= 1'b1;
                            state    <= VEND;
                        end
                    end
                end
                VEND: begin
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        credit   <= '0;
                        if (change_amt != '0) begin
                            change_units <= change_amt;
                            change_valid <= 1'b1;
                            state        <= CHANGE;
                        end else begin
                            busy  <= 1'b0;
                            state <= COLLECT;
                        end
                    end
                end
                CHANGE: begin
                    busy  <= 1'b0;
                    state <= COLLECT;
                end
                default: begin
                    disp_req <= 1'b0;
                    busy     <= 1'b0;
                    credit   <= '0;
                    state    <= COLLECT;
                end
            endcase
        end
    end

endmodule
